// File: rtl/cci_mpf_shim_throttle_pkg.sv
// Shared types and helpers for the MPF request throttle shim.
// Counter width, channel message structs and effective-limit function.
package cci_mpf_shim_throttle_pkg;

  localparam int THR_MAX_ACTIVE = 128;
  localparam int THR_SLACK      = 8;
  localparam int THR_CNT_W      = $clog2(THR_MAX_ACTIVE) + 1;

  typedef logic [THR_CNT_W-1:0] t_throttle_cnt;

  typedef enum logic [1:0] {
    C1_WRLINE = 2'd0,
    C1_FENCE  = 2'd1,
    C1_INTR   = 2'd2
  } t_c1_req;

  typedef enum logic {
    C0_RDLINE = 1'b0,
    C0_UMSG   = 1'b1
  } t_c0_rsp;

  typedef enum logic [1:0] {
    C1_WRRSP    = 2'd0,
    C1_FENCERSP = 2'd1,
    C1_INTRRSP  = 2'd2
  } t_c1_rsp;

  typedef struct packed {
    logic        valid;
    logic [1:0]  cl_len;
    logic [15:0] mdata;
    logic [41:0] addr;
  } t_c0_tx;

  typedef struct packed {
    logic        valid;
    t_c1_req     req_type;
    logic        sop;
    logic [1:0]  cl_len;
    logic [15:0] mdata;
    logic [41:0] addr;
    logic [63:0] data;
  } t_c1_tx;

  typedef struct packed {
    logic        valid;
    t_c0_rsp     rsp_type;
    logic        eop;
    logic [15:0] mdata;
    logic [63:0] data;
  } t_c0_rx;

  typedef struct packed {
    logic        valid;
    t_c1_rsp     rsp_type;
    logic        eop;
    logic [15:0] mdata;
  } t_c1_rx;

  // 0 means "use the ceiling"; tiny limits are lifted above the slack
  function automatic int unsigned throttle_eff_limit(
    input int unsigned csr,
    input int unsigned max,
    input int unsigned slack
  );
    int unsigned l;
    l = ((csr == 0) || (csr > max)) ? max : csr;
    if (l <= slack) l = slack + 1;
    return l;
  endfunction

endpackage

// File: rtl/cci_mpf_if.sv
// Simplified CCI channel bundle between MPF pipeline stages.
// to_fiu faces the FIU-side stage, to_afu faces the AFU-side stage.
interface cci_mpf_if;
  import cci_mpf_shim_throttle_pkg::*;

  logic   reset;
  t_c0_tx c0Tx;
  t_c1_tx c1Tx;
  logic   c0TxAlmFull;
  logic   c1TxAlmFull;
  t_c0_rx c0Rx;
  t_c1_rx c1Rx;

  modport to_fiu (
    output c0Tx, c1Tx,
    input  c0TxAlmFull, c1TxAlmFull,
    input  c0Rx, c1Rx
  );

  modport to_afu (
    output reset,
    input  c0Tx, c1Tx,
    output c0TxAlmFull, c1TxAlmFull,
    output c0Rx, c1Rx
  );

endinterface

// File: rtl/cci_mpf_shim_throttle_chan.sv
// One channel of the throttle: outstanding-packet counter,
// registered effective limit, almost-full and sticky error flags.
module cci_mpf_shim_throttle_chan
  import cci_mpf_shim_throttle_pkg::*;
#(
  parameter int MAX_ACTIVE_REQS = 128,
  parameter int ALM_FULL_SLACK  = 8,
  parameter int CNT_W = $clog2(MAX_ACTIVE_REQS) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic [CNT_W-1:0] limit,
  input  logic             fiu_alm_full,
  output logic [CNT_W-1:0] count,
  output logic             alm_full,
  output logic             ovf,
  output logic             udf
);

  localparam logic [CNT_W-1:0] CNT_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LIM_RST  = CNT_W'(MAX_ACTIVE_REQS);
  localparam logic [CNT_W:0]   SLACK_X  = (CNT_W+1)'(ALM_FULL_SLACK);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] lim_q;
  logic [CNT_W-1:0] lim_d;
  logic             udf_hit;
  logic             near_full;

  always_comb begin
    cnt_d   = cnt_q;
    udf_hit = 1'b0;
    unique case ({inc, dec})
      2'b10: begin
        if (cnt_q != CNT_ONES) cnt_d = cnt_q + CNT_ONE;
      end
      2'b01: begin
        if (cnt_q == '0) udf_hit = 1'b1;
        else cnt_d = cnt_q - CNT_ONE;
      end
      default: ;
    endcase
  end

  assign lim_d = CNT_W'(throttle_eff_limit(
                   32'(limit),
                   unsigned'(MAX_ACTIVE_REQS),
                   unsigned'(ALM_FULL_SLACK)));

  // Extra bit keeps count + slack from wrapping
  assign near_full = ({1'b0, cnt_d} + SLACK_X) >= {1'b0, lim_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      lim_q    <= LIM_RST;
      alm_full <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      lim_q    <= lim_d;
      alm_full <= fiu_alm_full | near_full;
      ovf      <= ovf | (cnt_d > lim_q);
      udf      <= udf | udf_hit;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/cci_mpf_shim_req_throttle.sv
// MPF stage limiting outstanding read and write/fence packets.
// Traffic passes through combinationally; only almost-full is added.
module cci_mpf_shim_req_throttle
  import cci_mpf_shim_throttle_pkg::*;
#(
  parameter int MAX_ACTIVE_REQS = 128,
  parameter int ALM_FULL_SLACK  = 8,
  parameter int CNT_W = $clog2(MAX_ACTIVE_REQS) + 1
) (
  input  logic             clk,
  input  logic             reset,
  cci_mpf_if.to_fiu        fiu,
  cci_mpf_if.to_afu        afu,
  input  logic [CNT_W-1:0] c0_max_active,
  input  logic [CNT_W-1:0] c1_max_active,
  output logic [CNT_W-1:0] c0_active,
  output logic [CNT_W-1:0] c1_active,
  output logic             err_overflow,
  output logic             err_underflow
);

  logic c0_inc;
  logic c0_dec;
  logic c1_inc;
  logic c1_dec;
  logic c0_ovf;
  logic c1_ovf;
  logic c0_udf;
  logic c1_udf;

  assign afu.reset = reset;
  assign fiu.c0Tx  = afu.c0Tx;
  assign fiu.c1Tx  = afu.c1Tx;
  assign afu.c0Rx  = fiu.c0Rx;
  assign afu.c1Rx  = fiu.c1Rx;

  assign c0_inc = afu.c0Tx.valid;
  assign c0_dec = fiu.c0Rx.valid & fiu.c0Rx.eop &
                  (fiu.c0Rx.rsp_type == C0_RDLINE);

  // Multi-beat writes count once, on the SOP beat
  always_comb begin
    c1_inc = 1'b0;
    unique case (1'b1)
      (afu.c1Tx.req_type == C1_WRLINE):
        c1_inc = afu.c1Tx.valid & afu.c1Tx.sop;
      (afu.c1Tx.req_type == C1_FENCE):
        c1_inc = afu.c1Tx.valid;
      default: ;
    endcase
  end

  always_comb begin
    c1_dec = 1'b0;
    unique case (1'b1)
      (fiu.c1Rx.rsp_type == C1_WRRSP),
      (fiu.c1Rx.rsp_type == C1_FENCERSP):
        c1_dec = fiu.c1Rx.valid & fiu.c1Rx.eop;
      default: ;
    endcase
  end

  cci_mpf_shim_throttle_chan #(
    .MAX_ACTIVE_REQS (MAX_ACTIVE_REQS),
    .ALM_FULL_SLACK  (ALM_FULL_SLACK),
    .CNT_W           (CNT_W)
  ) u_c0 (
    .clk          (clk),
    .reset        (reset),
    .inc          (c0_inc),
    .dec          (c0_dec),
    .limit        (c0_max_active),
    .fiu_alm_full (fiu.c0TxAlmFull),
    .count        (c0_active),
    .alm_full     (afu.c0TxAlmFull),
    .ovf          (c0_ovf),
    .udf          (c0_udf)
  );

  cci_mpf_shim_throttle_chan #(
    .MAX_ACTIVE_REQS (MAX_ACTIVE_REQS),
    .ALM_FULL_SLACK  (ALM_FULL_SLACK),
    .CNT_W           (CNT_W)
  ) u_c1 (
    .clk          (clk),
    .reset        (reset),
    .inc          (c1_inc),
    .dec          (c1_dec),
    .limit        (c1_max_active),
    .fiu_alm_full (fiu.c1TxAlmFull),
    .count        (c1_active),
    .alm_full     (afu.c1TxAlmFull),
    .ovf          (c1_ovf),
    .udf          (c1_udf)
  );

  assign err_overflow  = c0_ovf | c1_ovf;
  assign err_underflow = c0_udf | c1_udf;

endmodule

// File: tb/tb_cci_mpf_shim_req_throttle.sv
// Directed bench for the request throttle with a per-cycle model check.
// Model keeps integer counts and limits derived from the channel rules.
module tb_cci_mpf_shim_req_throttle;
  import cci_mpf_shim_throttle_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] c0_max_active;
  logic [7:0] c1_max_active;
  logic [7:0] c0_active;
  logic [7:0] c1_active;
  logic       err_overflow;
  logic       err_underflow;

  int checks = 0;
  int errors = 0;

  cci_mpf_if fiu_if ();
  cci_mpf_if afu_if ();

  cci_mpf_shim_req_throttle dut (
    .clk           (clk),
    .reset         (reset),
    .fiu           (fiu_if),
    .afu           (afu_if),
    .c0_max_active (c0_max_active),
    .c1_max_active (c1_max_active),
    .c0_active     (c0_active),
    .c1_active     (c1_active),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt0, m_cnt1, m_lim0, m_lim1;
  bit m_af0, m_af1, m_ovf, m_udf, m_valid;

  function automatic int eff(input int csr);
    int e;
    e = (csr == 0 || csr > 128) ? 128 : csr;
    if (e <= 8) e = 9;
    return e;
  endfunction

  always @(posedge clk) begin
    int i0, o0, i1, o1, n0, n1;
    if (reset) begin
      m_cnt0 = 0; m_cnt1 = 0;
      m_lim0 = 128; m_lim1 = 128;
      m_af0 = 0; m_af1 = 0; m_ovf = 0; m_udf = 0;
    end else begin
      i0 = int'(afu_if.c0Tx.valid);
      o0 = int'(fiu_if.c0Rx.valid && fiu_if.c0Rx.eop &&
                fiu_if.c0Rx.rsp_type == C0_RDLINE);
      i1 = int'(afu_if.c1Tx.valid &&
                ((afu_if.c1Tx.req_type == C1_WRLINE && afu_if.c1Tx.sop) ||
                 afu_if.c1Tx.req_type == C1_FENCE));
      o1 = int'(fiu_if.c1Rx.valid && fiu_if.c1Rx.eop &&
                fiu_if.c1Rx.rsp_type != C1_INTRRSP);
      n0 = m_cnt0 + i0 - o0;
      n1 = m_cnt1 + i1 - o1;
      if (n0 < 0) begin n0 = 0; m_udf = 1; end
      if (n1 < 0) begin n1 = 0; m_udf = 1; end
      if (n0 > 255) n0 = 255;
      if (n1 > 255) n1 = 255;
      if (n0 > m_lim0 || n1 > m_lim1) m_ovf = 1;
      m_af0 = fiu_if.c0TxAlmFull || (n0 + 8 >= m_lim0);
      m_af1 = fiu_if.c1TxAlmFull || (n1 + 8 >= m_lim1);
      m_cnt0 = n0;
      m_cnt1 = n1;
      m_lim0 = eff(int'(c0_max_active));
      m_lim1 = eff(int'(c1_max_active));
    end
    m_valid = 1;
  end

  always @(negedge clk) begin
    #2;
    if (m_valid) begin
      chk("m_c0_active", c0_active, 64'(m_cnt0));
      chk("m_c1_active", c1_active, 64'(m_cnt1));
      chk("m_c0_almfull", afu_if.c0TxAlmFull, m_af0);
      chk("m_c1_almfull", afu_if.c1TxAlmFull, m_af1);
      chk("m_err_overflow", err_overflow, m_ovf);
      chk("m_err_underflow", err_underflow, m_udf);
      chk("pass_c0tx", fiu_if.c0Tx == afu_if.c0Tx, 1);
      chk("pass_c1tx", fiu_if.c1Tx == afu_if.c1Tx, 1);
      chk("pass_c0rx", afu_if.c0Rx == fiu_if.c0Rx, 1);
      chk("pass_c1rx", afu_if.c1Rx == fiu_if.c1Rx, 1);
      chk("pass_reset", afu_if.reset, reset);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_all();
    afu_if.c0Tx = '0;
    afu_if.c1Tx = '0;
    fiu_if.c0Rx = '0;
    fiu_if.c1Rx = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); idle_all(); end
  endtask

  task automatic rd(input int n);
    repeat (n) begin
      @(negedge clk); idle_all();
      afu_if.c0Tx.valid = 1'b1;
      afu_if.c0Tx.addr  = 42'($urandom);
      afu_if.c0Tx.mdata = 16'($urandom);
    end
    @(negedge clk); idle_all();
  endtask

  task automatic wr(input int beats);
    for (int b = 0; b < beats; b++) begin
      @(negedge clk); idle_all();
      afu_if.c1Tx.valid    = 1'b1;
      afu_if.c1Tx.req_type = C1_WRLINE;
      afu_if.c1Tx.sop      = (b == 0);
      afu_if.c1Tx.cl_len   = 2'(beats - 1);
      afu_if.c1Tx.data     = {$urandom, $urandom};
    end
    @(negedge clk); idle_all();
  endtask

  task automatic c1_req(input t_c1_req ty);
    @(negedge clk); idle_all();
    afu_if.c1Tx.valid    = 1'b1;
    afu_if.c1Tx.req_type = ty;
    afu_if.c1Tx.sop      = 1'b1;
    @(negedge clk); idle_all();
  endtask

  task automatic rsp0(input bit eop, input t_c0_rsp ty);
    @(negedge clk); idle_all();
    fiu_if.c0Rx.valid    = 1'b1;
    fiu_if.c0Rx.rsp_type = ty;
    fiu_if.c0Rx.eop      = eop;
    fiu_if.c0Rx.data     = {$urandom, $urandom};
    @(negedge clk); idle_all();
  endtask

  task automatic rsp1(input bit eop, input t_c1_rsp ty);
    @(negedge clk); idle_all();
    fiu_if.c1Rx.valid    = 1'b1;
    fiu_if.c1Rx.rsp_type = ty;
    fiu_if.c1Rx.eop      = eop;
    @(negedge clk); idle_all();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); idle_all();
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    c0_max_active = 8'd0;
    c1_max_active = 8'd0;
    fiu_if.reset = 1'b0;
    fiu_if.c0TxAlmFull = 1'b0;
    fiu_if.c1TxAlmFull = 1'b0;
    idle_all();
    do_reset(2);
    chk("rst_c0_active", c0_active, 0);
    chk("rst_c0_almfull", afu_if.c0TxAlmFull, 0);
    chk("rst_ovf", err_overflow, 0);
    chk("rst_udf", err_underflow, 0);

    // default limit 128: almost-full exactly at 120 outstanding
    rd(119);
    chk("t1_af_119", afu_if.c0TxAlmFull, 0);
    chk("t1_cnt_119", c0_active, 119);
    rd(1);
    chk("t1_af_120", afu_if.c0TxAlmFull, 1);
    chk("t1_cnt_120", c0_active, 120);
    do_reset(1);
    chk("t1_rst_cnt", c0_active, 0);

    // c1: multi-beat writes count once, fences count, interrupts do not
    c1_max_active = 8'd16;
    cyc(2);
    repeat (4) wr(4);
    chk("t2_cnt_4", c1_active, 4);
    chk("t2_af", afu_if.c1TxAlmFull, 0);
    repeat (4) rsp1(1'b1, C1_WRRSP);
    chk("t2_cnt_0", c1_active, 0);
    c1_req(C1_FENCE);
    chk("t2_fence", c1_active, 1);
    c1_req(C1_INTR);
    chk("t2_intr", c1_active, 1);
    rsp1(1'b1, C1_INTRRSP);
    chk("t2_intr_rsp", c1_active, 1);
    rsp1(1'b0, C1_FENCERSP);
    chk("t2_fence_noeop", c1_active, 1);
    rsp1(1'b1, C1_FENCERSP);
    chk("t2_fence_rsp", c1_active, 0);

    // limit 20: almost-full at 12, released at 11
    c0_max_active = 8'd20;
    cyc(2);
    rd(11);
    chk("t3_af_11", afu_if.c0TxAlmFull, 0);
    rd(1);
    chk("t3_af_12", afu_if.c0TxAlmFull, 1);
    rsp0(1'b1, C0_RDLINE);
    chk("t3_cnt_11", c0_active, 11);
    chk("t3_af_rel", afu_if.c0TxAlmFull, 0);
    repeat (11) rsp0(1'b1, C0_RDLINE);

    // same-cycle inc/dec, non-EOP beat, unsolicited message
    rd(5);
    @(negedge clk); idle_all();
    afu_if.c0Tx.valid = 1'b1;
    fiu_if.c0Rx.valid = 1'b1;
    fiu_if.c0Rx.eop   = 1'b1;
    @(negedge clk); idle_all();
    chk("t4_same_cycle", c0_active, 5);
    rsp0(1'b0, C0_RDLINE);
    chk("t4_noeop", c0_active, 5);
    rsp0(1'b1, C0_UMSG);
    chk("t4_umsg", c0_active, 5);
    repeat (5) rsp0(1'b1, C0_RDLINE);
    chk("t4_drain", c0_active, 0);
    chk("t4_no_udf", err_underflow, 0);

    // underflow is sticky; overflow above limit 12
    rsp0(1'b1, C0_RDLINE);
    chk("t5_udf_cnt", c0_active, 0);
    chk("t5_udf", err_underflow, 1);
    cyc(3);
    chk("t5_udf_sticky", err_underflow, 1);
    c0_max_active = 8'd12;
    cyc(2);
    rd(12);
    chk("t5_no_ovf_12", err_overflow, 0);
    rd(1);
    chk("t5_ovf_13", err_overflow, 1);
    chk("t5_cnt_13", c0_active, 13);
    c1_max_active = 8'd4;
    cyc(2);
    c1_req(C1_FENCE);
    chk("t5_small_lim_af", afu_if.c1TxAlmFull, 1);

    // reset mid-operation, then FIU almost-full forwarding
    c0_max_active = 8'd0;
    c1_max_active = 8'd0;
    do_reset(1);
    rd(50);
    chk("t6_cnt_50", c0_active, 50);
    do_reset(1);
    chk("t6_cnt", c0_active, 0);
    chk("t6_c1_cnt", c1_active, 0);
    chk("t6_af", afu_if.c0TxAlmFull, 0);
    chk("t6_ovf", err_overflow, 0);
    chk("t6_udf", err_underflow, 0);
    @(negedge clk);
    fiu_if.c0TxAlmFull = 1'b1;
    @(negedge clk);
    chk("t6_fiu_af", afu_if.c0TxAlmFull, 1);
    fiu_if.c0TxAlmFull = 1'b0;
    @(negedge clk);
    chk("t6_fiu_af_rel", afu_if.c0TxAlmFull, 0);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cci_mpf_shim_req_throttle.md
Name: cci_mpf_shim_req_throttle

Overview:
MPF pipeline stage between the EOP-detect stage (FIU side) and the VTP stage (AFU side).
Counts outstanding read packets (c0) and write/fence packets (c1), and raises per-channel almost-full toward the AFU side when a programmable occupancy limit is approached.
Bounds in-flight traffic below the FIU's own limit, so the downstream sort/heap structures cannot be oversubscribed.
Requests and responses pass through unmodified with zero added latency.

Parameters:
MAX_ACTIVE_REQS, 128, hard ceiling on outstanding packets per channel; also the effective limit when a CSR limit is 0.
ALM_FULL_SLACK, 8, packets the AFU side may still issue after almost-full asserts.
CNT_W, $clog2(MAX_ACTIVE_REQS)+1, width of counters and limits.

Ports:
clk  input  1  pipeline clock
reset  input  1  synchronous, active-high reset
fiu  cci_mpf_if.to_fiu  -  toward EOP-detect stage; responses carry the EOP flag
afu  cci_mpf_if.to_afu  -  toward VTP stage
c0_max_active  input  CNT_W  CSR read limit; 0 selects MAX_ACTIVE_REQS; values above MAX_ACTIVE_REQS clamp to it
c1_max_active  input  CNT_W  CSR write limit; same rules as c0_max_active
c0_active  output  CNT_W  current outstanding read packets
c1_active  output  CNT_W  current outstanding write/fence packets
err_overflow  output  1  sticky; a channel count exceeded its effective limit
err_underflow  output  1  sticky; an EOP response arrived while the channel count was 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset. afu.reset is driven directly from reset.
- Datapath: all Tx/Rx request and response fields are wired straight through, with no added latency.
- c0 increment: +1 per valid read request (one multi-line read = 1 packet).
- c1 increment:
  - +1 per write request on its SOP beat only.
  - +1 per write fence.
  - Interrupt requests are not counted.
  - Non-SOP beats are not counted.
- c0 decrement: -1 per c0 read response with EOP set.
- c1 decrement: -1 per c1 write or fence response with EOP set.
- Non-EOP beats and unsolicited messages: ignored.
- Same-cycle increment and decrement on one channel: count unchanged.
- Effective limit per channel, registered 1 cycle after a CSR change:
  - L = MAX_ACTIVE_REQS if the CSR limit is 0.
  - Otherwise L = min(CSR, MAX_ACTIVE_REQS).
  - If L <= ALM_FULL_SLACK, L is forced to ALM_FULL_SLACK+1.
- afu.cNTxAlmFull is registered (1-cycle latency) and is asserted when either holds:
  - fiu.cNTxAlmFull = 1, or
  - next_count + ALM_FULL_SLACK >= L.
- Counter arithmetic:
  - CNT_W bits, unsigned.
  - Increment saturates at all-ones.
  - Decrement at 0 holds at 0 and sets err_underflow.
  - A count exceeding L sets err_overflow; counting continues.
- Reset values: counts 0, almost-full outputs 0, error flags 0, registered limits MAX_ACTIVE_REQS.
- Reset mid-operation: counts clear. Responses for pre-reset requests are decremented normally, so they may underflow and set err_underflow. Software must quiesce before reset.
- Error flags clear only on reset.

Decomposition:
- Package cci_mpf_shim_throttle_pkg: typedef t_throttle_cnt (logic [CNT_W-1:0]) and function throttle_eff_limit(csr, max, slack).
- One sub-module, cci_mpf_shim_throttle_chan, instantiated per channel:
  - Inputs: inc, dec, limit, fiu_alm_full.
  - Outputs: count, alm_full, ovf, udf.
- Top level only decodes request/response classes (SOP, fence, EOP) and wires the two instances.

Test Plan:
1. c0_max_active=0, defaults; issue 120 reads with no responses -> afu.c0TxAlmFull=0 after read 119, 1 the cycle after read 120 (120+8>=128); c0_active=120.
2. c1_max_active=16; issue 4 four-beat writes (16 beats) -> c1_active=4; then 4 EOP write responses -> c1_active=0; almost-full never asserts.
3. c0_max_active=20; issue 12 reads -> almost-full=1 (12+8>=20); one EOP response -> almost-full deasserts next cycle (11+8<20).
4. Same-cycle c0 request and c0 EOP response at count 5 -> count stays 5; a c0 response without EOP -> count unchanged.
5. c0 EOP response at count 0 -> count stays 0, err_underflow=1 and stays set until reset; c0_max_active=12, issue 13 reads -> err_overflow=1.
6. Reset asserted with c0_active=50 -> next cycle counts 0, almost-full 0, flags 0; fiu.c0TxAlmFull=1 -> afu.c0TxAlmFull=1 one cycle later regardless of count.
